mac_stream_src: RTL and testbench

Operand stream source for the MAC accelerator kernel. It accepts a single 32-bit input stream of interleaved operand pairs (a0, b0, a1, b1, …) and buffers them as pairs. It drives the a/b operand streams, plus one c word per job in scalar-product mode, toward the MAC datapath with compliant valid/ready behaviour. It sits between the streamer/loader and the MAC kernel and sequences one job of reg_len+1 products per start pulse.

---
 rtl/mac_stream_src_pkg.sv | 14 +
 rtl/mac_pair_fifo.sv | 76 +++++++
 rtl/mac_stream_src.sv | 137 +++++++++++++
 tb/tb_mac_stream_src.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stream_src_pkg.sv
// Shared definitions for the MAC operand stream source.
// CNT_LEN is shared with the MAC kernel.
package mac_stream_src_pkg;

    localparam int CNT_LEN = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        C      = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mac_pair_fifo.sv
// First-word-fall-through FIFO of operand pairs.
// Full and empty flags are registered, so readiness never depends combinationally on pop.
module mac_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full_q | pop);
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (PW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mac_stream_src.sv
// Operand stream source: deinterleaves {a,b} words into a pair FIFO and
// sequences one job of reg_len+1 pairs (plus an optional c word) per start.
module mac_stream_src #(
    parameter int CNT_LEN    = mac_stream_src_pkg::CNT_LEN,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       start,
    input  logic [$clog2(CNT_LEN)-1:0] reg_len,
    input  logic                       reg_simple_mul,
    input  logic [31:0]                reg_c_init,
    input  logic                       in_TVALID,
    output logic                       in_TREADY,
    input  logic [31:0]                in_TDATA,
    output logic                       a_TVALID,
    input  logic                       a_TREADY,
    output logic [31:0]                a_TDATA,
    output logic                       b_TVALID,
    input  logic                       b_TREADY,
    output logic [31:0]                b_TDATA,
    output logic                       c_TVALID,
    input  logic                       c_TREADY,
    output logic [31:0]                c_TDATA,
    output logic                       busy,
    output logic                       done
);
    import mac_stream_src_pkg::*;

    localparam int LW = $clog2(CNT_LEN);
    localparam int CW = LW + 1;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [31:0]   hold_q, hold_d;
    logic [LW-1:0] len_q, len_d;
    logic          simple_q, simple_d;
    logic [31:0]   c_init_q, c_init_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    logic          in_hs;
    logic          push;
    logic          pair_valid;
    logic          pair_hs;

    // Phase B (phase_q=1) completes a pair; phase A only fills the hold register.
    assign in_TREADY = ~phase_q | ~fifo_full;
    assign in_hs     = in_TVALID & in_TREADY;
    assign push      = in_hs & phase_q;

    assign pair_valid = (state_q == STREAM) & ~fifo_empty;
    assign pair_hs    = pair_valid & a_TREADY & b_TREADY;

    mac_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .push      (push),
        .push_data ({hold_q, in_TDATA}),
        .pop       (pair_hs),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q ^ in_hs;
        hold_d   = (in_hs & ~phase_q) ? in_TDATA : hold_q;
        len_d    = len_q;
        simple_d = simple_q;
        c_init_d = c_init_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = reg_len;
                    simple_d = reg_simple_mul;
                    c_init_d = reg_c_init;
                    cnt_d    = '0;
                    state_d  = reg_simple_mul ? STREAM : C;
                end
            end
            C: begin
                if (c_TREADY) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pair_hs) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            hold_q   <= '0;
            len_q    <= '0;
            simple_q <= 1'b0;
            c_init_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            len_q    <= len_d;
            simple_q <= simple_d;
            c_init_q <= c_init_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data is forced to zero whenever valid is low so idle outputs are clean.
    assign a_TVALID = pair_valid;
    assign b_TVALID = pair_valid;
    assign a_TDATA  = pair_valid ? fifo_head[63:32] : '0;
    assign b_TDATA  = pair_valid ? fifo_head[31:0]  : '0;
    assign c_TVALID = (state_q == C);
    assign c_TDATA  = (state_q == C) ? c_init_q : '0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mac_stream_src.sv
// Directed bench for mac_stream_src: a table of jobs plus hand-written
// backpressure and reset-flush sequences.
module tb_mac_stream_src;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start;
    logic [11:0] reg_len;
    logic        reg_simple_mul;
    logic [31:0] reg_c_init;
    logic        in_TVALID;
    logic        in_TREADY;
    logic [31:0] in_TDATA;
    logic        a_TVALID, a_TREADY;
    logic [31:0] a_TDATA;
    logic        b_TVALID, b_TREADY;
    logic [31:0] b_TDATA;
    logic        c_TVALID, c_TREADY;
    logic [31:0] c_TDATA;
    logic        busy, done;

    always #5 ap_clk = ~ap_clk;

    mac_stream_src #(
        .CNT_LEN    (4096),
        .FIFO_DEPTH (4)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .start          (start),
        .reg_len        (reg_len),
        .reg_simple_mul (reg_simple_mul),
        .reg_c_init     (reg_c_init),
        .in_TVALID      (in_TVALID),
        .in_TREADY      (in_TREADY),
        .in_TDATA       (in_TDATA),
        .a_TVALID       (a_TVALID),
        .a_TREADY       (a_TREADY),
        .a_TDATA        (a_TDATA),
        .b_TVALID       (b_TVALID),
        .b_TREADY       (b_TREADY),
        .b_TDATA        (b_TDATA),
        .c_TVALID       (c_TVALID),
        .c_TREADY       (c_TREADY),
        .c_TDATA        (c_TDATA),
        .busy           (busy),
        .done           (done)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input word feeder: drains feed_q onto the in stream, one word per handshake.
    logic [31:0] feed_q [$];
    bit          feed_hs;

    initial begin
        in_TVALID = 1'b0;
        in_TDATA  = '0;
        forever begin
            @(negedge ap_clk);
            feed_hs = in_TVALID && in_TREADY && ap_rst_n;
            @(posedge ap_clk);
            if (feed_hs) void'(feed_q.pop_front());
            #1;
            if (feed_q.size() > 0) begin
                in_TVALID = 1'b1;
                in_TDATA  = feed_q[0];
            end else begin
                in_TVALID = 1'b0;
                in_TDATA  = '0;
            end
        end
    end

    // Output monitor: records pair and c handshakes, done pulses, and checks
    // that stalled a/b valid and data hold until the handshake.
    logic [63:0] got_q [$];
    int          done_cnt;
    int          c_cnt;
    int          c_cyc;
    int          a_first_cyc;
    logic [31:0] c_last;
    bit          stall_pend = 1'b0;
    logic [31:0] pa, pb;

    initial begin
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    check("hold_stable", {31'd0, a_TVALID, a_TDATA}, {31'd0, 1'b1, pa});
                    check("hold_stable_b", 64'(b_TDATA), 64'(pb));
                end
                stall_pend = a_TVALID && !(a_TREADY && b_TREADY);
                pa = a_TDATA;
                pb = b_TDATA;
                if (a_TVALID && a_TREADY && b_TREADY) got_q.push_back({a_TDATA, b_TDATA});
                if (a_TVALID && a_first_cyc < 0) a_first_cyc = cyc;
                if (c_TVALID && c_TREADY) begin
                    c_cnt++;
                    c_last = c_TDATA;
                    c_cyc  = cyc;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic feed(input logic [31:0] base, input int nwords);
        for (int i = 0; i < nwords; i++) feed_q.push_back(base + 32'(i));
        repeat (30) @(posedge ap_clk);
    endtask

    task automatic run_job(input logic simple, input logic [11:0] len, input logic [31:0] cinit,
                           input int stall_after, input bit restart,
                           input int exp_n, input logic [31:0] exp_a);
        bit          seen;
        logic [31:0] ea;
        got_q.delete();
        done_cnt    = 0;
        c_cnt       = 0;
        c_cyc       = -1;
        a_first_cyc = -1;
        @(posedge ap_clk); #1;
        start          = 1'b1;
        reg_simple_mul = simple;
        reg_len        = len;
        reg_c_init     = cinit;
        @(posedge ap_clk); #1;
        start      = 1'b0;
        reg_len    = len + 12'd5;
        reg_c_init = ~cinit;
        check("busy_at_start", 64'(busy), 64'd1);
        check("c_valid_at_start", 64'(c_TVALID), 64'(!simple));
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == stall_after) a_TREADY = 1'b0;
            if (k == stall_after + 5) a_TREADY = 1'b1;
            if (restart && k == 1) begin
                start          = 1'b1;
                reg_len        = 12'd7;
                reg_simple_mul = ~simple;
            end
            if (restart && k == 2) start = 1'b0;
            @(posedge ap_clk); #1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        start    = 1'b0;
        a_TREADY = 1'b1;
        @(posedge ap_clk); #1;
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_width", 64'(done), 64'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("pair_count", 64'(got_q.size()), 64'(exp_n));
        for (int i = 0; i < got_q.size(); i++) begin
            ea = exp_a + 32'(2 * i);
            check("pair_data", got_q[i], {ea, ea + 32'd1});
        end
        check("c_count", 64'(c_cnt), simple ? 64'd0 : 64'd1);
        if (!simple) begin
            check("c_data", 64'(c_last), 64'(cinit));
            check("c_before_ab", 64'(c_cyc < a_first_cyc), 64'd1);
        end
        $display("job simple=%0b len=%0d: %0d pairs, first a=0x%0h", simple, len, got_q.size(), exp_a);
    endtask

    typedef struct {
        logic        simple;
        logic [11:0] len;
        logic [31:0] cinit;
        int          nwords;
        logic [31:0] base;
        int          stall_after;
        bit          restart;
        int          exp_n;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // simple, len, c_init, words, base, stall, restart, exp pairs, exp first a
        vecs[0] = '{1'b1, 12'd3, 32'h0,        8,  32'd1,   -1, 1'b0, 4, 32'd1};
        vecs[1] = '{1'b0, 12'd0, 32'h10,       2,  32'h20,  -1, 1'b0, 1, 32'h20};
        vecs[2] = '{1'b1, 12'd1, 32'h0,        12, 32'd101, -1, 1'b0, 2, 32'd101};
        vecs[3] = '{1'b1, 12'd3, 32'h0,        0,  32'd0,   -1, 1'b0, 4, 32'd105};
        vecs[4] = '{1'b0, 12'd2, 32'hDEADBEEF, 6,  32'h30,  -1, 1'b1, 3, 32'h30};

        start          = 1'b0;
        reg_len        = '0;
        reg_simple_mul = 1'b0;
        reg_c_init     = '0;
        a_TREADY       = 1'b1;
        b_TREADY       = 1'b1;
        c_TREADY       = 1'b1;

        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_in_ready", 64'(in_TREADY), 64'd1);
        check("rst_valids", {61'd0, a_TVALID, b_TVALID, c_TVALID}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_data", {a_TDATA, b_TDATA}, 64'd0);
        check("rst_c_data", 64'(c_TDATA), 64'd0);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            feed(vecs[i].base, vecs[i].nwords);
            run_job(vecs[i].simple, vecs[i].len, vecs[i].cinit, vecs[i].stall_after,
                    vecs[i].restart, vecs[i].exp_n, vecs[i].exp_a);
        end

        // Backpressure: FIFO full plus a word in hold blocks the phase-B word.
        feed(32'h200, 16);
        check("full_in_ready", 64'(in_TREADY), 64'd0);
        run_job(1'b1, 12'd7, 32'h0, 2, 1'b0, 8, 32'h200);

        // Reset mid-job with an odd word count leaves a word in hold.
        feed(32'h900, 3);
        a_TREADY = 1'b0;
        @(posedge ap_clk); #1;
        start          = 1'b1;
        reg_simple_mul = 1'b1;
        reg_len        = 12'd5;
        @(posedge ap_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_pre_valid", 64'(a_TVALID), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_valids", {61'd0, a_TVALID, b_TVALID, c_TVALID}, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_TREADY), 64'd1);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        a_TREADY = 1'b1;
        feed(32'd9, 2);
        run_job(1'b1, 12'd0, 32'h0, -1, 1'b0, 1, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
